// File: rtl/pit_irq_pkg.sv
// Shared types, default parameters and helpers for the PIT interrupt collector.
package pit_irq_pkg;

    localparam int MAX_SRC      = 16;
    localparam int DEF_NUM_SRC  = 4;
    localparam int DEF_ID_W     = 2;
    localparam int DEF_MISS_W   = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } irq_state_e;

    // Lowest set bit wins; returns 0 for an all-zero vector.
    function automatic logic [3:0] lowest_set_index(input logic [MAX_SRC-1:0] vec);
        lowest_set_index = 4'd0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_set_index = 4'(i);
            end
        end
    endfunction

endpackage

// File: rtl/pit_irq_prio_enc.sv
// Combinational lowest-index-first priority encoder with an any-valid flag.
module pit_irq_prio_enc
    import pit_irq_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [ID_W-1:0]    idx,
    output logic               any_valid
);

    logic [MAX_SRC-1:0] req_ext;

    generate
        for (genvar gi = 0; gi < MAX_SRC; gi++) begin : g_ext
            if (gi < NUM_SRC) begin : g_src
                assign req_ext[gi] = req[gi];
            end else begin : g_pad
                assign req_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign idx       = ID_W'(lowest_set_index(req_ext));
    assign any_valid = |req;

endmodule

// File: rtl/pit_irq_collector.sv
// Collects timer interrupt pulses into sticky pending bits and presents one
// masked, lowest-index-first interrupt to the host until it is acknowledged.
module pit_irq_collector
    import pit_irq_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int ID_W    = DEF_ID_W,
    parameter int MISS_W  = DEF_MISS_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_pulse,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               irq_ack,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask,
    output logic [MISS_W-1:0]  miss_count
);

    localparam int                SUM_W    = MISS_W + 5;
    localparam logic [MISS_W-1:0] MISS_MAX = '1;

    irq_state_e         state_reg, state_next;
    logic [ID_W-1:0]    irq_id_reg, irq_id_next;
    logic [NUM_SRC-1:0] pending_reg, pending_next;
    logic [NUM_SRC-1:0] mask_reg;
    logic [MISS_W-1:0]  miss_count_reg, miss_count_next;

    logic [NUM_SRC-1:0] clear_vec;
    logic [NUM_SRC-1:0] lost_vec;
    logic [4:0]         lost_cnt;
    logic [SUM_W-1:0]   miss_sum;
    logic               ack_fire;
    logic [ID_W-1:0]    enc_idx;
    logic               enc_valid;

    assign ack_fire = (state_reg == ACTIVE) && irq_ack;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_clear
            assign clear_vec[gi] = ack_fire && (irq_id_reg == ID_W'(gi));
        end
    endgenerate

    // A new pulse overrides the ack clear, so it is never lost in that case.
    assign pending_next = (pending_reg & ~clear_vec) | src_pulse;
    assign lost_vec     = src_pulse & pending_reg & ~clear_vec;

    always_comb begin
        lost_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            lost_cnt = lost_cnt + 5'(lost_vec[i]);
        end
        miss_sum        = SUM_W'(miss_count_reg) + SUM_W'(lost_cnt);
        miss_count_next = (miss_sum > SUM_W'(MISS_MAX)) ? MISS_MAX : miss_sum[MISS_W-1:0];
    end

    pit_irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req       (pending_reg & mask_reg),
        .idx       (enc_idx),
        .any_valid (enc_valid)
    );

    // Selection happens only from IDLE; once ACTIVE the choice is frozen.
    always_comb begin
        state_next  = state_reg;
        irq_id_next = irq_id_reg;
        case (state_reg)
            IDLE: begin
                if (enc_valid) begin
                    state_next  = ACTIVE;
                    irq_id_next = enc_idx;
                end
            end
            ACTIVE: begin
                if (irq_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            irq_id_reg     <= '0;
            pending_reg    <= '0;
            mask_reg       <= '0;
            miss_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            irq_id_reg     <= irq_id_next;
            pending_reg    <= pending_next;
            miss_count_reg <= miss_count_next;
            if (mask_we) begin
                mask_reg <= mask_wdata;
            end
        end
    end

    assign irq        = (state_reg == ACTIVE);
    assign irq_id     = irq_id_reg;
    assign pending    = pending_reg;
    assign mask       = mask_reg;
    assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_pit_irq_collector.sv
// Directed bench for pit_irq_collector: stimulus pushes hand-computed expected
// state into a scoreboard queue, an independent monitor compares each cycle.
module tb_pit_irq_collector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] src_pulse = '0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_wdata = '0;
    logic       irq_ack = 1'b0;
    logic       irq;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] mask;
    logic [7:0] miss_count;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic       irq;
        logic [1:0] id;
        logic       chk_id;
        logic [3:0] pend;
        logic [3:0] mask;
        logic [7:0] miss;
    } exp_t;

    exp_t sb[$];

    pit_irq_collector #(
        .NUM_SRC (4),
        .ID_W    (2),
        .MISS_W  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .src_pulse  (src_pulse),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .irq_ack    (irq_ack),
        .irq        (irq),
        .irq_id     (irq_id),
        .pending    (pending),
        .mask       (mask),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Apply one cycle of inputs, then record the state expected after that edge.
    task automatic step(input logic [3:0] p, input logic ack, input logic we,
                        input logic [3:0] wd, input logic rst, input string name,
                        input logic e_irq, input logic [1:0] e_id, input logic e_chk,
                        input logic [3:0] e_pend, input logic [3:0] e_mask,
                        input logic [7:0] e_miss);
        exp_t e;
        src_pulse  = p;
        irq_ack    = ack;
        mask_we    = we;
        mask_wdata = wd;
        reset      = rst;
        @(posedge clk);
        #1;
        src_pulse = '0;
        irq_ack   = 1'b0;
        mask_we   = 1'b0;
        reset     = 1'b0;
        e.cyc = cyc; e.name = name; e.irq = e_irq; e.id = e_id; e.chk_id = e_chk;
        e.pend = e_pend; e.mask = e_mask; e.miss = e_miss;
        sb.push_back(e);
    endtask

    // Monitor: compares scoreboard entries due this cycle, on the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (e.cyc != cyc || irq !== e.irq || (e.chk_id && irq_id !== e.id) ||
                pending !== e.pend || mask !== e.mask || miss_count !== e.miss) begin
                miscompares++;
                $display("FAIL %s @%0d: got irq=%b id=%0d pend=%b mask=%b miss=%0d, want irq=%b id=%0d pend=%b mask=%b miss=%0d",
                         e.name, cyc, irq, irq_id, pending, mask, miss_count,
                         e.irq, e.id, e.pend, e.mask, e.miss);
            end else begin
                $display("vec %0d %s ok", vectors, e.name);
            end
        end
    end

    initial begin
        // Reset
        step(4'b0000, 0, 0, 4'b0000, 1, "reset",      0, 0, 1, 4'b0000, 4'b0000, 0);
        step(4'b0000, 0, 0, 4'b0000, 0, "post_reset", 0, 0, 1, 4'b0000, 4'b0000, 0);

        // Single source, full latency and ack
        step(4'b0000, 0, 1, 4'b0001, 0, "mask1",      0, 0, 0, 4'b0000, 4'b0001, 0);
        step(4'b0001, 0, 0, 4'b0000, 0, "p0_pend",    0, 0, 0, 4'b0001, 4'b0001, 0);
        step(4'b0000, 0, 0, 4'b0000, 0, "p0_irq",     1, 0, 1, 4'b0001, 4'b0001, 0);
        step(4'b0000, 0, 0, 4'b0000, 0, "p0_hold1",   1, 0, 1, 4'b0001, 4'b0001, 0);
        step(4'b0000, 0, 0, 4'b0000, 0, "p0_hold2",   1, 0, 1, 4'b0001, 4'b0001, 0);
        step(4'b0000, 1, 0, 4'b0000, 0, "p0_ack",     0, 0, 0, 4'b0000, 4'b0001, 0);
        step(4'b0000, 0, 0, 4'b0000, 0, "p0_idle",    0, 0, 0, 4'b0000, 4'b0001, 0);

        // Two sources at once: lowest index first, gap, then the other
        step(4'b0000, 0, 1, 4'b1111, 0, "maskf",      0, 0, 0, 4'b0000, 4'b1111, 0);
        step(4'b1010, 0, 0, 4'b0000, 0, "p31_pend",   0, 0, 0, 4'b1010, 4'b1111, 0);
        step(4'b0000, 0, 0, 4'b0000, 0, "p31_irq1",   1, 1, 1, 4'b1010, 4'b1111, 0);
        step(4'b0000, 1, 0, 4'b0000, 0, "p31_ack1",   0, 0, 0, 4'b1000, 4'b1111, 0);
        step(4'b0000, 0, 0, 4'b0000, 0, "p31_irq3",   1, 3, 1, 4'b1000, 4'b1111, 0);
        step(4'b0000, 1, 0, 4'b0000, 0, "p31_ack3",   0, 0, 0, 4'b0000, 4'b1111, 0);

        // Masked source latches, presented after unmask; then reset while ACTIVE
        step(4'b0000, 0, 1, 4'b0000, 0, "mask0",      0, 0, 0, 4'b0000, 4'b0000, 0);
        step(4'b0100, 0, 0, 4'b0000, 0, "p2_masked",  0, 0, 0, 4'b0100, 4'b0000, 0);
        step(4'b0000, 0, 0, 4'b0000, 0, "p2_noirq",   0, 0, 0, 4'b0100, 4'b0000, 0);
        step(4'b0000, 0, 1, 4'b0100, 0, "unmask2",    0, 0, 0, 4'b0100, 4'b0100, 0);
        step(4'b0000, 0, 0, 4'b0000, 0, "p2_irq",     1, 2, 1, 4'b0100, 4'b0100, 0);
        step(4'b0000, 0, 0, 4'b0000, 1, "rst_active", 0, 0, 1, 4'b0000, 4'b0000, 0);
        step(4'b0000, 1, 0, 4'b0000, 0, "idle_ack1",  0, 0, 1, 4'b0000, 4'b0000, 0);
        step(4'b0000, 1, 0, 4'b0000, 0, "idle_ack2",  0, 0, 1, 4'b0000, 4'b0000, 0);

        // Lost-pulse saturation
        step(4'b0000, 0, 1, 4'b0001, 0, "sat_mask",   0, 0, 0, 4'b0000, 4'b0001, 0);
        step(4'b0001, 0, 0, 4'b0000, 0, "sat_pend",   0, 0, 0, 4'b0001, 4'b0001, 0);
        step(4'b0000, 0, 0, 4'b0000, 0, "sat_irq",    1, 0, 1, 4'b0001, 4'b0001, 0);
        for (int k = 1; k <= 300; k++) begin
            step(4'b0001, 0, 0, 4'b0000, 0, "sat_miss", 1, 0, 1, 4'b0001, 4'b0001,
                 (k < 255) ? 8'(k) : 8'd255);
        end
        step(4'b0000, 0, 0, 4'b0000, 0, "sat_hold",   1, 0, 1, 4'b0001, 4'b0001, 255);
        step(4'b0000, 0, 0, 4'b0000, 1, "sat_reset",  0, 0, 1, 4'b0000, 4'b0000, 0);

        // Ack and same-source pulse together: set wins, no miss
        step(4'b0000, 0, 1, 4'b0001, 0, "sw_mask",    0, 0, 0, 4'b0000, 4'b0001, 0);
        step(4'b0001, 0, 0, 4'b0000, 0, "sw_pend",    0, 0, 0, 4'b0001, 4'b0001, 0);
        step(4'b0000, 0, 0, 4'b0000, 0, "sw_irq",     1, 0, 1, 4'b0001, 4'b0001, 0);
        step(4'b0001, 1, 0, 4'b0000, 0, "sw_ackset",  0, 0, 0, 4'b0001, 4'b0001, 0);
        step(4'b0000, 0, 0, 4'b0000, 0, "sw_reirq",   1, 0, 1, 4'b0001, 4'b0001, 0);

        // Two lost pulses in one cycle, then mask the presented source while ACTIVE
        step(4'b0010, 0, 0, 4'b0000, 0, "m2_pend1",   1, 0, 1, 4'b0011, 4'b0001, 0);
        step(4'b0011, 0, 0, 4'b0000, 0, "m2_lost2",   1, 0, 1, 4'b0011, 4'b0001, 2);
        step(4'b0000, 0, 1, 4'b0000, 0, "mk_active",  1, 0, 1, 4'b0011, 4'b0000, 2);
        step(4'b0000, 1, 0, 4'b0000, 0, "mk_ack",     0, 0, 0, 4'b0010, 4'b0000, 2);
        step(4'b0000, 0, 0, 4'b0000, 0, "mk_idle",    0, 0, 0, 4'b0010, 4'b0000, 2);

        // Let the monitor drain, bounded
        for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pit_irq_collector.md
Name: pit_irq_collector

Overview:
- Sits directly downstream of the programmable interval timer(s).
- Captures their one-cycle interrupt pulses into sticky pending bits, applies a per-source mask, and selects the highest-priority pending source.
- Presents one level-sensitive interrupt with a source ID to the JTAG-visible register logic / host, and holds it until acknowledged.
- Counts pulses lost because their source was already pending.

Parameters:
- NUM_SRC, 4: number of interrupt sources (1..16).
- ID_W, 2: width of source ID. Must satisfy 2**ID_W >= NUM_SRC.
- MISS_W, 8: width of the saturating lost-pulse counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- src_pulse  in  NUM_SRC  one-cycle interrupt pulses from timers; bit i = source i.
- mask_we  in  1  write strobe for mask register.
- mask_wdata  in  NUM_SRC  new mask value; 1 = source enabled.
- irq_ack  in  1  one-cycle acknowledge of the currently presented interrupt.
- irq  out  1  level interrupt to host.
- irq_id  out  ID_W  index of the presented source; valid while irq=1.
- pending  out  NUM_SRC  raw pending bits, including masked sources.
- mask  out  NUM_SRC  current mask register.
- miss_count  out  MISS_W  saturating count of lost pulses.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: irq=0, irq_id=0, pending=0, mask=0 (all sources disabled), miss_count=0, FSM=IDLE.
- Reset asserted mid-operation discards everything, including an in-flight irq, on that edge.
- Pending capture:
  - src_pulse[i]=1 at edge N sets pending[i], visible at N+1.
  - A pulse arrives while pending[i] is already 1 and is not being cleared that cycle: miss_count increments by 1.
  - miss_count saturates at 2**MISS_W-1 and never wraps.
  - Pulses on k sources in the same cycle that are all lost increment miss_count by k, clamped at saturation.
- Mask:
  - mask_we=1 loads mask_wdata at the edge.
  - Masked sources still latch pending but are never presented.
- FSM states: IDLE, ACTIVE.
  - IDLE: if (pending & mask) != 0, select the lowest index i among set bits. Next cycle: ACTIVE, irq=1, irq_id=i.
  - Latency: pulse at edge N -> pending at N+1 -> irq at N+2 (source unmasked).
  - ACTIVE: irq and irq_id are held stable regardless of new pulses, mask changes or higher-priority arrivals. No preemption.
  - ACTIVE with irq_ack=1: pending[irq_id] clears, irq=0, FSM returns to IDLE, all next cycle. irq therefore stays low for at least one cycle between two consecutive interrupts.
  - irq_ack in IDLE is ignored; no state change.
- Simultaneous events:
  - Ack clear and a new src_pulse on the same source in the same cycle: set wins, pending stays 1, not counted as a miss.
  - Masking the presented source while ACTIVE does not retract irq. The ack still clears it.
- Writing 0 to the mask while pending bits exist leaves them pending. Unmasking later presents them.

Decomposition:
- Package pit_irq_pkg:
  - FSM state enum (IDLE, ACTIVE).
  - Default parameter constants.
  - Function lowest_set_index(vector) -> ID_W index.
- One natural sub-module: pit_irq_prio_enc, a combinational lowest-index-first priority encoder with an any-valid output.
- Pending, miss counter and FSM live in the top module.

Test Plan:
- Reset, then mask=4'b0001, pulse src0 at cycle 10 -> pending=0001 at 11; irq=1, irq_id=0 at 12; ack at 15 -> irq=0, pending=0000 at 16.
- Mask=4'b1111, pulses src3 and src1 in the same cycle -> irq_id=1 first; after ack, one idle cycle with irq=0, then irq_id=3; after second ack, pending=0000.
- Mask=4'b0000, pulse src2 -> pending=0100, irq stays 0; write mask=0100 -> irq=1, irq_id=2 two cycles after the write edge.
- src0 pending, unacked; 300 further src0 pulses -> miss_count saturates at 255 and holds; reset -> miss_count=0.
- ACTIVE on src0 while a src0 pulse coincides with irq_ack -> pending[0] stays 1, miss_count unchanged, irq reasserts with id 0 after the one-cycle gap.
- ACTIVE on src2, assert reset for one cycle -> next cycle irq=0, pending=0, mask=0; irq_ack pulses in IDLE cause no change.
